// File: rtl/board_generator_if.sv
// Wishbone classic write channel between the board generator and the board memory.
interface wishbone_if #(
  parameter int ADR_W = 8,
  parameter int DAT_W = 8
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic             ack;

  modport master (output cyc, stb, we, adr, dat_w, input ack);
  modport slave  (input cyc, stb, we, adr, dat_w, output ack);
endinterface

// File: rtl/board_generator.sv
// Builds a Minesweeper board (mines + neighbour counts) and streams every cell
// into the board memory over a Wishbone classic write port.
module board_generator #(
  parameter int          BOARD_SIZE = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [$clog2(BOARD_SIZE):0]            active_size,
  input  logic [$clog2(BOARD_SIZE*BOARD_SIZE):0] mine_count,
  input  logic [$clog2(BOARD_SIZE)-1:0]          safe_row,
  input  logic [$clog2(BOARD_SIZE)-1:0]          safe_col,
  output logic                                   busy,
  output logic                                   done,
  wishbone_if.master                             master_wr
);

  localparam int IW    = $clog2(BOARD_SIZE);
  localparam int CELLS = BOARD_SIZE * BOARD_SIZE;
  localparam int AW    = $clog2(CELLS);
  localparam int SW    = IW + 1;
  localparam int MW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_WRITE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [SW-1:0] size;
    logic [MW-1:0] eff;
    logic [IW-1:0] safe_r;
    logic [IW-1:0] safe_c;
  } cfg_t;

  state_t             state;
  cfg_t               cfg;
  cfg_t               cfg_in;
  logic [15:0]        lfsr;
  logic [CELLS-1:0]   bitmap;
  logic [MW-1:0]      placed;

  logic [IW-1:0]      cand_r;
  logic [IW-1:0]      cand_c;
  logic [AW-1:0]      cand_idx;
  logic               cand_ok;
  int                 cand_dr;
  int                 cand_dc;

  logic [AW-1:0]      calc_adr;
  logic [AW-1:0]      nb_idx;
  logic [3:0]         nb_cnt;
  logic [7:0]         calc_dat;
  int                 calc_r;
  int                 calc_c;
  int                 nb_r;
  int                 nb_c;
  int                 cfg_sz;
  int                 cfg_sq;

  // Oversized requests are clipped to the board, then the mine count is clamped
  // so the 3x3 first-click window always fits.
  // NOTE: every variable written in an always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cfg_sz        = (int'(active_size) > BOARD_SIZE) ? BOARD_SIZE : int'(active_size);
    cfg_sq        = cfg_sz * cfg_sz;
    cfg_in.size   = SW'(cfg_sz);
    cfg_in.safe_r = safe_row;
    cfg_in.safe_c = safe_col;
    if (cfg_sq < 9)
      cfg_in.eff = '0;
    else if (int'(mine_count) > cfg_sq - 9)
      cfg_in.eff = MW'(cfg_sq - 9);
    else
      cfg_in.eff = mine_count;
  end

  always_comb begin
    cand_r   = IW'(lfsr[7:4]);
    cand_c   = IW'(lfsr[3:0]);
    cand_idx = AW'(int'(cand_r) * BOARD_SIZE + int'(cand_c));
    cand_dr  = int'(cand_r) - int'(cfg.safe_r);
    cand_dc  = int'(cand_c) - int'(cfg.safe_c);
    cand_ok  = (int'(cand_r) < int'(cfg.size)) &&
               (int'(cand_c) < int'(cfg.size)) &&
               !bitmap[cand_idx] &&
               !(cand_dr >= -1 && cand_dr <= 1 && cand_dc >= -1 && cand_dc <= 1);
  end

  // Data for the address about to be presented: 0 when leaving PLACE, else adr+1.
  always_comb begin
    calc_adr = (state == S_WRITE) ? AW'(master_wr.adr + 1'b1) : '0;
    calc_r   = int'(calc_adr) / BOARD_SIZE;
    calc_c   = int'(calc_adr) % BOARD_SIZE;
    nb_cnt   = '0;
    nb_r     = 0;
    nb_c     = 0;
    nb_idx   = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nb_r   = calc_r + dr;
        nb_c   = calc_c + dc;
        nb_idx = AW'(nb_r * BOARD_SIZE + nb_c);
        if ((dr != 0 || dc != 0) &&
            nb_r >= 0 && nb_r < int'(cfg.size) &&
            nb_c >= 0 && nb_c < int'(cfg.size) &&
            bitmap[nb_idx])
          nb_cnt = nb_cnt + 4'd1;
      end
    end
    if (calc_r < int'(cfg.size) && calc_c < int'(cfg.size))
      calc_dat = {3'b000, bitmap[calc_adr], nb_cnt};
    else
      calc_dat = 8'h00;
  end

  // Taps 16,14,13,11 in the right-shifting Fibonacci form; runs every cycle.
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // NOTE: the bitmap has no reset; CLEAR zeroes it before every use, so a reset
  // network on 256 flops would buy nothing.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      bitmap <= '0;
    else if (state == S_PLACE && placed != cfg.eff && cand_ok)
      bitmap[cand_idx] <= 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cfg             <= '0;
      placed          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      master_wr.cyc   <= 1'b0;
      master_wr.stb   <= 1'b0;
      master_wr.we    <= 1'b0;
      master_wr.adr   <= '0;
      master_wr.dat_w <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cfg   <= cfg_in;
            busy  <= 1'b1;
            state <= S_CLEAR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          placed <= '0;
          state  <= S_PLACE;
        end
        S_PLACE: begin
          if (placed == cfg.eff) begin
            state           <= S_WRITE;
            master_wr.cyc   <= 1'b1;
            master_wr.stb   <= 1'b1;
            master_wr.we    <= 1'b1;
            master_wr.adr   <= calc_adr;
            master_wr.dat_w <= calc_dat;
          end else if (cand_ok) begin
            placed <= placed + 1'b1;
          end
        end
        S_WRITE: begin
          if (master_wr.stb) begin
            if (master_wr.ack) begin
              master_wr.cyc <= 1'b0;
              master_wr.stb <= 1'b0;
              master_wr.we  <= 1'b0;
            end
          end else if (master_wr.adr == AW'(CELLS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            // Idle slot over: present the next cell.
            master_wr.cyc   <= 1'b1;
            master_wr.stb   <= 1'b1;
            master_wr.we    <= 1'b1;
            master_wr.adr   <= calc_adr;
            master_wr.dat_w <= calc_dat;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_generator.sv
// Randomised self-checking bench for board_generator: Wishbone slave with
// configurable ack delay, address/data scoreboard and board-level reference checks.
module tb_board_generator;

  localparam int BS    = 16;
  localparam int CELLS = BS * BS;
  localparam int LIMIT = 20000;

  typedef struct {
    int adr;
    bit zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] active_size;
  logic [8:0] mine_count;
  logic [3:0] safe_row;
  logic [3:0] safe_col;
  logic       busy;
  logic       done;

  int   total = 0;
  int   bad   = 0;
  int   cyc_ctr = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  int   writes_seen = 0;
  int   done_cnt = 0;
  int   last_ack_cyc = 0;
  bit   sb_en = 1'b0;
  bit   prev_stall = 1'b0;
  bit   prev_acked = 1'b0;
  int   prev_adr = 0;
  int   prev_dat = 0;
  exp_t exp_q[$];
  logic [7:0] board [CELLS];

  wishbone_if #(.ADR_W(8), .DAT_W(8)) wb ();

  board_generator #(.BOARD_SIZE(BS), .LFSR_SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .active_size (active_size),
    .mine_count  (mine_count),
    .safe_row    (safe_row),
    .safe_col    (safe_col),
    .busy        (busy),
    .done        (done),
    .master_wr   (wb.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  // Slave: acks after ack_delay stalled cycles.
  assign wb.ack = wb.cyc && wb.stb && (wait_cnt >= ack_delay);
  always @(posedge clk) begin
    if (wb.cyc && wb.stb && !wb.ack) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: protocol checks and scoreboard pop on every acked write.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sb_en) begin
        check("busy_low_at_done", int'(busy), 0);
        check("writes_left_at_done", exp_q.size(), 0);
        check("done_latency", cyc_ctr - last_ack_cyc, 2);
      end
    end
    if (!rst && sb_en) begin
      if (prev_stall) begin
        check("stall_stb_held", int'(wb.stb), 1);
        check("stall_adr_held", int'(wb.adr), prev_adr);
        check("stall_dat_held", int'(wb.dat_w), prev_dat);
      end
      if (prev_acked) check("idle_after_ack", int'(wb.stb), 0);
      if (wb.cyc && wb.stb && wb.ack) begin
        writes_seen++;
        last_ack_cyc = cyc_ctr;
        check("we_high", int'(wb.we), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_write_adr", int'(wb.adr), -1);
        end else begin
          e = exp_q.pop_front();
          check("write_adr", int'(wb.adr), e.adr);
          if (e.zero) check("dat_zero", int'(wb.dat_w), 0);
          else        check("dat_flags_clear", int'(wb.dat_w[7:5]), 0);
          board[wb.adr] = wb.dat_w;
        end
      end
      prev_stall = wb.cyc && wb.stb && !wb.ack;
      prev_acked = wb.stb && wb.ack;
      prev_adr   = int'(wb.adr);
      prev_dat   = int'(wb.dat_w);
    end else begin
      prev_stall = 1'b0;
      prev_acked = 1'b0;
    end
  end

  task automatic run_board(input int sz, input int mc, input int sr, input int sc,
                           input int delay, input bit poke);
    int   sq, eff, n, mines, near_safe, nb_bad, cnt, nr, nc;
    bit   poked;
    exp_t e;
    sq  = sz * sz;
    eff = (sq < 9) ? 0 : ((mc < sq - 9) ? mc : sq - 9);
    ack_delay = delay;
    exp_q.delete();
    for (int a = 0; a < CELLS; a++) begin
      e.adr  = a;
      e.zero = (a / BS >= sz) || (a % BS >= sz) || (eff == 0);
      exp_q.push_back(e);
      board[a] = 8'hFF;
    end
    writes_seen = 0;
    done_cnt    = 0;
    sb_en       = 1'b1;
    poked       = 1'b0;

    @(negedge clk);
    active_size = 5'(sz);
    mine_count  = 9'(mc);
    safe_row    = 4'(sr);
    safe_col    = 4'(sc);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);

    n = 0;
    while (done_cnt == 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (start) start = 1'b0;
      if (poke && !poked && writes_seen >= 50) begin
        start       = 1'b1;
        active_size = 5'd4;
        mine_count  = 9'd0;
        safe_row    = 4'd0;
        safe_col    = 4'd0;
        poked       = 1'b1;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("write_count", writes_seen, CELLS);
    check("busy_after_done", int'(busy), 0);

    // Reference: mine total, first-click exclusion and neighbour recount.
    mines = 0; near_safe = 0; nb_bad = 0;
    for (int r = 0; r < sz; r++) begin
      for (int c = 0; c < sz; c++) begin
        if (board[r*BS+c][4]) begin
          mines++;
          if (r - sr >= -1 && r - sr <= 1 && c - sc >= -1 && c - sc <= 1) near_safe++;
        end
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            nr = r + dr;
            nc = c + dc;
            if ((dr != 0 || dc != 0) && nr >= 0 && nr < sz && nc >= 0 && nc < sz &&
                board[nr*BS+nc][4])
              cnt++;
          end
        end
        if (int'(board[r*BS+c][3:0]) != cnt) nb_bad++;
      end
    end
    check("mine_total", mines, eff);
    check("mines_near_safe", near_safe, 0);
    check("neighbour_mismatches", nb_bad, 0);
    sb_en = 1'b0;
  endtask

  initial begin
    int found, n;
    rst = 1'b1; start = 1'b1;
    active_size = 5'd8; mine_count = 9'd10; safe_row = 4'd0; safe_col = 4'd0;

    // Reset with start held high: rst must win.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_cyc", int'(wb.cyc), 0);
      check("rst_stb", int'(wb.stb), 0);
      check("rst_we", int'(wb.we), 0);
      check("rst_adr", int'(wb.adr), 0);
      check("rst_dat", int'(wb.dat_w), 0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("busy_after_rst", int'(busy), 0);

    run_board(8, 0, 3, 3, 0, 1'b0);
    run_board(16, 40, 0, 0, 0, 1'b0);
    run_board(8, 200, 2, 5, 0, 1'b0);
    run_board(3, 5, 1, 1, 0, 1'b0);
    run_board(16, 20, 15, 15, 3, 1'b1);

    // Reset mid-write at address 100.
    done_cnt = 0;
    @(negedge clk);
    active_size = 5'd16; mine_count = 9'd30; safe_row = 4'd4; safe_col = 4'd4;
    ack_delay = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0; n = 0;
    while (!found && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (wb.stb && wb.adr == 8'd100) found = 1;
    end
    check("reached_adr100", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_stb", int'(wb.stb), 0);
    check("abort_cyc", int'(wb.cyc), 0);
    check("abort_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    run_board(16, 30, 7, 9, 0, 1'b0);

    for (int k = 0; k < 4; k++)
      run_board(int'($urandom_range(1, 16)), int'($urandom_range(0, 300)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
